// File: rtl/ex_mem_buffer.sv
// EX->MEM elastic stage register: two-entry skid buffer toward MEM, branch
// resolution from the ALU compare bit, and a saturating EX stall counter.
module ex_mem_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic                      ex_branch,
  input  logic [DATA_WIDTH-1:0]     ex_br_target,
  input  logic                      flush,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [DATA_WIDTH-1:0]     mem_alu_result,
  output logic [DATA_WIDTH-1:0]     mem_store_data,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic                      mem_reg_write,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic                      br_taken,
  output logic [DATA_WIDTH-1:0]     br_target,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  // state | meaning
  // EMPTY | no beats held, mem_valid low
  // ONE   | main register holds the head beat
  // FULL  | main holds the head, skid holds the next beat; EX is stalled

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
  } beat_t;

  state_t state;
  beat_t  main_q;
  beat_t  skid_q;
  beat_t  in_beat;
  logic   live_q;
  logic   accept;
  logic   enq;
  logic   drain;

  // live_q holds ready low for the first cycle after reset releases
  assign ex_ready = rst_n & live_q & (state != FULL);
  assign accept   = ex_valid & ex_ready;
  assign enq      = accept & ~ex_branch;
  assign drain    = mem_valid & mem_ready;

  assign in_beat = '{alu_result: ex_alu_result, store_data: ex_store_data, rd: ex_rd,
                     reg_write: ex_reg_write, mem_read: ex_mem_read, mem_write: ex_mem_write};

  assign mem_valid      = (state != EMPTY);
  assign mem_alu_result = main_q.alu_result;
  assign mem_store_data = main_q.store_data;
  assign mem_rd         = main_q.rd;
  assign mem_reg_write  = main_q.reg_write;
  assign mem_mem_read   = main_q.mem_read;
  assign mem_mem_write  = main_q.mem_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      live_q    <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
      stall_cnt <= '0;
    end else begin
      live_q <= 1'b1;

      if (ex_valid && !ex_ready && (stall_cnt != {CNT_WIDTH{1'b1}}))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);

      br_taken <= accept & ex_branch & ~flush & ex_alu_result[0];
      if (accept && ex_branch && !flush)
        br_target <= ex_br_target;

      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (enq) begin
              main_q <= in_beat;
              state  <= ONE;
            end
          end
          ONE: begin
            if (enq && !drain) begin
              skid_q <= in_beat;
              state  <= FULL;
            end else if (enq && drain) begin
              main_q <= in_beat;
            end else if (drain) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            if (drain) begin
              main_q <= skid_q;
              state  <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Scoreboard bench for ex_mem_buffer: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_ex_mem_buffer;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [DW-1:0] ex_alu_result = '0;
  logic [DW-1:0] ex_store_data = '0;
  logic [RW-1:0] ex_rd = '0;
  logic          ex_reg_write = 1'b0;
  logic          ex_mem_read = 1'b0;
  logic          ex_mem_write = 1'b0;
  logic          ex_branch = 1'b0;
  logic [DW-1:0] ex_br_target = '0;
  logic          flush = 1'b0;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_store_data;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_write;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic          br_taken;
  logic [DW-1:0] br_target;
  logic [CW-1:0] stall_cnt;

  ex_mem_buffer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_br_target(ex_br_target), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .br_taken(br_taken), .br_target(br_target), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic [DW-1:0] sd;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          mw;
  } tb_beat_t;

  tb_beat_t exp_q[$];
  bit       m_live = 0;
  int       m_stall = 0;
  bit       m_br = 0;
  logic [DW-1:0] m_tgt = '0;
  bit       mon_en = 0;
  int       checks = 0;
  int       errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return rst_n && m_live && (exp_q.size() < 2);
  endfunction

  // Reference model: a two-deep FIFO of beats, updated on each rising edge
  always @(posedge clk) begin
    bit rdy, acc, drn;
    tb_beat_t b;
    rdy = model_ready();
    acc = ex_valid && rdy;
    drn = (exp_q.size() > 0) && mem_ready;
    if (!rst_n) begin
      exp_q.delete();
      m_live = 0; m_stall = 0; m_br = 0; m_tgt = '0;
    end else begin
      m_live = 1;
      if (ex_valid && !rdy && m_stall < CMAX) m_stall++;
      m_br = 0;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (drn) void'(exp_q.pop_front());
        if (acc && ex_branch) begin
          m_br  = ex_alu_result[0];
          m_tgt = ex_br_target;
        end else if (acc) begin
          b.res = ex_alu_result; b.sd = ex_store_data; b.rd = ex_rd;
          b.rw = ex_reg_write; b.mr = ex_mem_read; b.mw = ex_mem_write;
          exp_q.push_back(b);
        end
      end
    end
  end

  // Monitor: compare DUT outputs against the model away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ex_ready", ex_ready, model_ready());
      chk("mem_valid", mem_valid, exp_q.size() != 0);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("br_taken", br_taken, m_br);
      if (m_br) chk("br_target", br_target, m_tgt);
      if (mem_valid && exp_q.size() > 0) begin
        chk("mem_alu_result", mem_alu_result, exp_q[0].res);
        chk("mem_store_data", mem_store_data, exp_q[0].sd);
        chk("mem_rd", mem_rd, exp_q[0].rd);
        chk("mem_ctrl", {mem_reg_write, mem_mem_read, mem_mem_write},
            {exp_q[0].rw, exp_q[0].mr, exp_q[0].mw});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [DW-1:0] res, bit br, logic [DW-1:0] tgt);
    ex_valid      = v;
    ex_alu_result = res;
    ex_branch     = br;
    ex_br_target  = tgt;
    ex_store_data = $urandom;
    ex_rd         = RW'($urandom);
    ex_reg_write  = 1'($urandom);
    ex_mem_read   = 1'($urandom);
    ex_mem_write  = 1'($urandom);
  endtask

  // Present a beat and hold it until the model says it was accepted
  task automatic send(logic [DW-1:0] res, bit br = 0, logic [DW-1:0] tgt = '0);
    bit acc;
    drive(1, res, br, tgt);
    for (int i = 0; i < 100; i++) begin
      acc = model_ready();
      step();
      if (acc) begin
        ex_valid = 0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout actual=not_accepted required=accepted res=%0h", res);
    ex_valid = 0;
  endtask

  task automatic fill_full();
    mem_ready = 0;
    send(32'hA1);
    send(32'hA2);
  endtask

  task automatic drain_all();
    ex_valid = 0; flush = 0; mem_ready = 1;
    repeat (4) step();
  endtask

  initial begin
    rst_n = 0;
    @(posedge clk);
    #1 mon_en = 1;
    step();
    chk("reset_ex_ready", ex_ready, 0);
    chk("reset_mem_valid", mem_valid, 0);
    rst_n = 1;
    step();
    chk("ready_after_reset", ex_ready, 1);

    // Streaming
    mem_ready = 1;
    send(32'h10); chk("stream0", mem_alu_result, 32'h10);
    send(32'h20); chk("stream1", mem_alu_result, 32'h20);
    send(32'h30); chk("stream2", mem_alu_result, 32'h30);
    chk("stream_ready", ex_ready, 1);
    chk("stream_stall", stall_cnt, 0);
    step();

    // Backpressure
    mem_ready = 0;
    send(32'h11);
    send(32'h22);
    drive(1, 32'h33, 0, '0);
    repeat (3) step();
    chk("bp_stall", stall_cnt, 3);
    chk("bp_ready", ex_ready, 0);
    chk("bp_head", mem_alu_result, 32'h11);
    mem_ready = 1;
    send(32'h33);
    drain_all();

    // Branches, with a held beat to confirm mem_valid is unaffected
    mem_ready = 0;
    send(32'h55);
    send(32'h1, 1, 32'h40);
    chk("br_taken_1", br_taken, 1);
    chk("br_target_1", br_target, 32'h40);
    chk("br_mem_valid", mem_valid, 1);
    chk("br_head", mem_alu_result, 32'h55);
    send(32'h0, 1, 32'h80);
    chk("br_not_taken", br_taken, 0);
    send(32'hFFFF_FFFE, 1, 32'h90);
    chk("br_upper_ignored", br_taken, 0);
    step();
    chk("br_pulse_end", br_taken, 0);
    drain_all();

    // Flush in FULL drops the simultaneous beat
    fill_full();
    drive(1, 32'h99, 0, '0);
    flush = 1;
    step();
    flush = 0; ex_valid = 0;
    chk("flush_mem_valid", mem_valid, 0);
    chk("flush_ready", ex_ready, 1);
    mem_ready = 1;
    send(32'h77);
    chk("after_flush_head", mem_alu_result, 32'h77);
    drain_all();

    // Flush beats a same-cycle taken branch
    mem_ready = 0;
    send(32'h12);
    drive(1, 32'h1, 1, 32'h44);
    flush = 1;
    step();
    flush = 0; ex_valid = 0;
    chk("flush_br", br_taken, 0);
    drain_all();

    // Reset mid-operation
    fill_full();
    rst_n = 0;
    step();
    chk("mid_rst_ready", ex_ready, 0);
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_outs", {mem_alu_result, mem_store_data, mem_rd, mem_reg_write,
                         mem_mem_read, mem_mem_write, br_taken}, '0);
    chk("mid_rst_br_target", br_target, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    rst_n = 1;
    step();
    chk("post_rst_ready", ex_ready, 1);
    chk("post_rst_stall", stall_cnt, 0);

    // Saturation
    fill_full();
    drive(1, 32'hBB, 0, '0);
    repeat (20) step();
    chk("stall_saturate", stall_cnt, CMAX);
    drain_all();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 5) == 0), $urandom);
      mem_ready = 1'($urandom);
      flush     = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1;
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_buffer.md
Name: ex_mem_buffer

Overview:
- Elastic EX→MEM stage register sitting directly downstream of the ALU.
- Captures ALUResult plus the instruction's control and destination fields, and resolves beq/bne from the ALU's Equal/NotEqual result (bit 0).
- Presents a two-entry skid-buffered valid/ready interface to the memory stage, so MEM backpressure never creates a combinational path back into EX.
- Counts EX stall cycles for performance debug.

Parameters:
- DATA_WIDTH, 32, width of ALU result, store data and branch target.
- REG_ADDR_WIDTH, 5, width of destination register index.
- CNT_WIDTH, 16, width of saturating stall counter.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- ex_valid  input  1  EX beat valid
- ex_ready  output  1  buffer can accept a beat
- ex_alu_result  input  DATA_WIDTH  ALU output for this beat
- ex_store_data  input  DATA_WIDTH  rs2 data for stores
- ex_rd  input  REG_ADDR_WIDTH  destination register
- ex_reg_write  input  1  writes register file
- ex_mem_read  input  1  load
- ex_mem_write  input  1  store
- ex_branch  input  1  beat is a conditional branch (ALU ran Equal/NotEqual)
- ex_br_target  input  DATA_WIDTH  precomputed PC+imm
- flush  input  1  discard all buffered beats
- mem_valid  output  1  head beat valid toward MEM
- mem_ready  input  1  MEM accepts head beat
- mem_alu_result  output  DATA_WIDTH  head ALU result / address
- mem_store_data  output  DATA_WIDTH  head store data
- mem_rd  output  REG_ADDR_WIDTH  head destination
- mem_reg_write  output  1  head control
- mem_mem_read  output  1  head control
- mem_mem_write  output  1  head control
- br_taken  output  1  one-cycle pulse, branch resolved taken
- br_target  output  DATA_WIDTH  target, valid when br_taken=1
- stall_cnt  output  CNT_WIDTH  saturating count of ex_valid & !ex_ready cycles

Behaviour:
- Definitions: accept = ex_valid & ex_ready; drain = mem_valid & mem_ready.
- Reset (rst_n=0 at clk edge):
  - State goes to EMPTY.
  - mem_valid, all mem_* outputs, br_taken, br_target and stall_cnt go to 0.
  - ex_ready is forced to 0 while rst_n=0 and rises the cycle after reset deasserts.
  - Reset mid-operation discards all buffered beats.
- States and ex_ready: EMPTY (no beats), ONE (main register valid), FULL (main and skid valid).
  - ex_ready = (state != FULL), a registered-state decode only; it has no dependence on mem_ready.
- Transitions (non-branch accepts only):
  - EMPTY: accept → ONE, main ← beat.
  - ONE: accept & !drain → FULL, skid ← beat. accept & drain → ONE, main ← beat. !accept & drain → EMPTY. Otherwise hold.
  - FULL: drain → ONE, main ← skid. Otherwise hold. No accept is possible in FULL.
- Outputs: mem_valid = (state != EMPTY); mem_* always driven from the main register. Latency is 1 cycle from accept to mem_valid when EMPTY.
- Ordering: strict FIFO order; the skid entry never overtakes main.
- Branch beats (accept & ex_branch):
  - Not enqueued; state is unaffected by that beat.
  - Next cycle: br_taken = ex_alu_result[0] and br_target = ex_br_target; otherwise br_taken=0.
  - br_taken is a single-cycle pulse per taken branch.
  - Non-zero upper result bits are ignored.
  - A branch accept in ONE with a simultaneous drain still performs the drain (→ EMPTY).
- Flush:
  - Synchronous. State → EMPTY and mem_valid=0 next cycle.
  - Has priority over a same-cycle accept: the beat is dropped and no br_taken is generated.
  - stall_cnt is unaffected.
- Control fields: mem_reg_write, mem_mem_read and mem_mem_write are registered with the beat exactly as presented; no qualification.
- Stall counter: increments by 1 on each cycle with ex_valid & !ex_ready; saturates at all-ones and does not wrap.
- Held outputs: while mem_valid=1 and mem_ready=0, all mem_* outputs must remain stable.

Test Plan:
- Streaming: ex_valid=1 continuously with results 0x10, 0x20, 0x30 and mem_ready=1 → mem_alu_result shows 0x10, 0x20, 0x30 on consecutive cycles starting 1 cycle after the first accept; ex_ready stays 1; stall_cnt=0.
- Backpressure: hold mem_ready=0 and send A=0x11, B=0x22 → state FULL, ex_ready=0, mem_alu_result=0x11 stable. A third beat held for 3 cycles gives stall_cnt=3. Raise mem_ready → output order 0x11, 0x22, then the third beat; nothing is lost or duplicated.
- Branch: accept ex_branch=1, ex_alu_result=0x1, ex_br_target=0x0000_0040 → next cycle br_taken=1 and br_target=0x40, mem_valid unchanged. The same with ex_alu_result=0x0 → br_taken=0.
- Flush: in FULL, assert flush together with ex_valid=1 → next cycle mem_valid=0, ex_ready=1; the dropped beat never appears on mem_*.
- Reset mid-operation: in FULL, drive rst_n=0 for one cycle → all outputs 0 and ex_ready=0 during reset; ex_ready=1 the following cycle; stall_cnt=0.
- Saturation: with CNT_WIDTH=4, hold ex_valid=1 in FULL for 20 cycles → stall_cnt=0xF, no wrap.
